spi_txn_sched: RTL

Upstream transaction scheduler for spi_top.
- Accepts 12-bit words from a producer over a valid/ready stream and buffers them in a small FIFO.
- Issues one spi_top transaction per word by driving newd and din, then waits for done.
- Returns the captured dout on a valid/ready result stream.
- Replaces hand-driven newd/din sequencing with a backpressured, timeout-protected front end.

---
 rtl/spi_txn_pkg.sv | 23 ++
 rtl/spi_txn_sched_if.sv | 23 ++
 rtl/spi_txn_fifo.sv | 56 +++++
 rtl/spi_txn_sched.sv | 139 +++++++++++++
 4 files changed

// File: rtl/spi_txn_pkg.sv
// Shared types, defaults and sizing helpers for the SPI transaction scheduler.
package spi_txn_pkg;

    localparam int DW_DEFAULT      = 12;
    localparam int NEWD_DEFAULT    = 16;
    localparam int TIMEOUT_DEFAULT = 1024;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // One shared counter times both the newd pulse and the done timeout.
    function automatic int ctr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

    localparam int CTR_W_DEFAULT = ctr_width(NEWD_DEFAULT, TIMEOUT_DEFAULT);

endpackage

// File: rtl/spi_txn_sched_if.sv
// Producer and consumer valid/ready streams of the SPI transaction scheduler.
interface spi_txn_sched_if import spi_txn_pkg::*; #(
    parameter int DW = DW_DEFAULT
) ();

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

endinterface

// File: rtl/spi_txn_fifo.sv
// Synchronous word FIFO; push is ignored when full, pop is ignored when empty.
module spi_txn_fifo import spi_txn_pkg::*; #(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DW-1:0]          din,
    output logic [DW-1:0]          dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_level == (AW+1)'(DEPTH));
    assign empty  = (r_level == '0);
    assign level  = r_level;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/spi_txn_sched.sv
// Buffers producer words, runs one spi_top newd/done transaction per word and
// returns the captured dout on a result stream, with a done timeout.
module spi_txn_sched import spi_txn_pkg::*; #(
    parameter int DW             = DW_DEFAULT,
    parameter int DEPTH          = 4,
    parameter int NEWD_CYCLES    = NEWD_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_txn_sched_if.slave         bus,
    output logic                   spi_newd,
    output logic [DW-1:0]          spi_din,
    input  logic [DW-1:0]          spi_dout,
    input  logic                   spi_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err,
    output logic [CNT_W-1:0]       txn_cnt
);

    localparam int            TW           = ctr_width(NEWD_CYCLES, TIMEOUT_CYCLES);
    localparam logic [TW-1:0] NEWD_LAST    = TW'(NEWD_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                 r_state;
    logic [TW-1:0]          r_cnt;
    logic                   r_done_q;
    logic                   r_newd;
    logic [DW-1:0]          r_din;
    logic                   r_err;
    logic                   r_m_valid;
    logic [DW-1:0]          r_m_data;
    logic [CNT_W-1:0]       r_txn_cnt;

    logic                   w_done_rise;
    logic                   w_slot_free;
    logic                   w_launch;
    logic                   w_capture;
    logic                   w_timeout;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [DW-1:0]          w_fifo_dout;
    logic [$clog2(DEPTH):0] w_level;

    spi_txn_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.s_valid),
        .pop   (w_launch),
        .din   (bus.s_data),
        .dout  (w_fifo_dout),
        .level (w_level),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // The result slot counts as free when the consumer drains it this cycle.
    assign w_done_rise = spi_done & ~r_done_q;
    assign w_slot_free = ~r_m_valid | bus.m_ready;
    assign w_launch    = (r_state == IDLE) & ~w_fifo_empty & w_slot_free;
    assign w_capture   = ((r_state == LAUNCH) | (r_state == WAIT_DONE)) & w_done_rise;
    assign w_timeout   = (r_state == WAIT_DONE) & ~w_done_rise & (r_cnt == TIMEOUT_LAST);

    assign bus.s_ready = ~w_fifo_full;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign spi_newd    = r_newd;
    assign spi_din     = r_din;
    assign busy        = (r_state != IDLE);
    assign level       = w_level;
    assign err         = r_err;
    assign txn_cnt     = r_txn_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_done_q  <= 1'b0;
            r_newd    <= 1'b0;
            r_din     <= '0;
            r_err     <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_txn_cnt <= '0;
        end else begin
            r_done_q <= spi_done;
            r_err    <= w_timeout;

            if (w_capture) begin
                r_m_data  <= spi_dout;
                r_txn_cnt <= r_txn_cnt + CNT_W'(1);
            end

            // A capture in the same cycle as a drain keeps the slot full.
            if (w_capture) begin
                r_m_valid <= 1'b1;
            end else if (bus.m_ready) begin
                r_m_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state <= LAUNCH;
                        r_din   <= w_fifo_dout;
                        r_cnt   <= '0;
                        r_newd  <= 1'b1;
                    end
                end
                LAUNCH: begin
                    if (w_capture) begin
                        r_state <= IDLE;
                        r_newd  <= 1'b0;
                    end else if (r_cnt == NEWD_LAST) begin
                        r_state <= WAIT_DONE;
                        r_newd  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (w_capture || w_timeout) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
